// File: rtl/spram_param_ctrl.sv
// Parametrised single-port synchronous RAM with byte strobes, selectable
// read-during-write behaviour, registered read and a fill-value clear engine.
module spram_param_ctrl #(
  parameter int unsigned        DATA_W         = 32,
  parameter int unsigned        ADDR_W         = 6,
  parameter int unsigned        DEPTH          = 64,
  parameter int unsigned        RDW_MODE       = 0,
  parameter bit                 CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0]  FILL_VALUE     = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  input  logic                  clear_req,
  output logic [DATA_W-1:0]     rdata,
  output logic                  rvalid,
  output logic                  ready,
  output logic                  err
);

  localparam int unsigned       STRB_W   = DATA_W / 8;
  localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t              state_r;
  logic [ADDR_W-1:0]   ptr_r;
  logic [DATA_W-1:0]   mem_r [DEPTH];
  logic [DATA_W-1:0]   rdata_r;
  logic                rvalid_r;
  logic                err_r;

  logic                ready_s;
  logic                in_range_s;
  logic                mem_we_s;
  logic [ADDR_W-1:0]   mem_addr_s;
  logic [DATA_W-1:0]   mem_wdata_s;
  logic [DATA_W-1:0]   old_word_s;
  logic [DATA_W-1:0]   merged_s;

  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [STRB_W-1:0] strb
  );
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int i = 0; i < int'(STRB_W); i++) begin
      if (strb[i]) begin
        res[8*i +: 8] = new_w[8*i +: 8];
      end
    end
    return res;
  endfunction

  // Access decode and the single memory write port (sweep has priority)
  always_comb begin
    ready_s     = (state_r == ST_IDLE) && !reset;
    in_range_s  = ({1'b0, addr} < DEPTH_W);
    old_word_s  = mem_r[addr];
    merged_s    = merge_bytes(old_word_s, wdata, wstrb);
    mem_we_s    = 1'b0;
    mem_addr_s  = addr;
    mem_wdata_s = merged_s;
    if ((state_r == ST_CLEAR) && !reset) begin
      mem_we_s    = 1'b1;
      mem_addr_s  = ptr_r;
      mem_wdata_s = FILL_VALUE;
    end else if (ready_s && en && we && in_range_s && !clear_req) begin
      mem_we_s    = 1'b1;
      mem_addr_s  = addr;
      mem_wdata_s = merged_s;
    end else begin
      mem_we_s    = 1'b0;
    end
  end

  // Storage array; no reset so it maps onto RAM macros
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_addr_s] <= mem_wdata_s;
    end
  end

  // Controller state, clear pointer and registered read/error outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      ptr_r    <= '0;
      rdata_r  <= '0;
      rvalid_r <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      rvalid_r <= 1'b0;
      err_r    <= 1'b0;
      case (state_r)
        ST_CLEAR: begin
          if (ptr_r == LAST_PTR) begin
            state_r <= ST_IDLE;
            ptr_r   <= '0;
          end else begin
            ptr_r   <= ptr_r + ADDR_W'(1);
          end
        end
        ST_IDLE: begin
          if (clear_req) begin
            state_r <= ST_CLEAR;
            ptr_r   <= '0;
          end else if (en) begin
            if (!in_range_s) begin
              err_r <= 1'b1;
            end else if (!we) begin
              rdata_r  <= old_word_s;
              rvalid_r <= 1'b1;
            end else if (RDW_MODE == 32'd1) begin
              rdata_r  <= old_word_s;
              rvalid_r <= 1'b1;
            end else if (RDW_MODE == 32'd2) begin
              rdata_r  <= merged_s;
              rvalid_r <= 1'b1;
            end else begin
              rdata_r  <= rdata_r;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          ptr_r   <= '0;
        end
      endcase
    end
  end

  assign rdata  = rdata_r;
  assign rvalid = rvalid_r;
  assign err    = err_r;
  assign ready  = ready_s;

endmodule
